// File: rtl/vga_timing_out.sv
// 640x480@60 VGA timing generator: drives row-fetch control for the row buffer and
// produces pipeline-aligned syncs plus RGB565-decoded colour (or colour bars).
module vga_timing_out #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_TOTAL     = 800,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_TOTAL     = 525,
  parameter int PIPE_LAT    = 2,
  parameter int ROW_REQ_LEN = 40,
  parameter int SWAP_BYTES  = 1
) (
  input  logic        clk_25M,
  input  logic        rst_n_25M,
  input  logic [15:0] pixel_data,
  input  logic        test_pattern,
  output logic [9:0]  vga_h_counter,
  output logic [9:0]  vga_v_counter,
  output logic        start_frame,
  output logic        start_row,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [4:0]  vga_r,
  output logic [5:0]  vga_g,
  output logic [4:0]  vga_b,
  output logic        frame_done
);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] ROW_END    = 10'(H_VISIBLE + ROW_REQ_LEN);
  localparam logic [9:0] V_ROW_LAST = 10'(V_VISIBLE - 1);
  localparam int         BAR_W      = H_VISIBLE / 8;

  logic [9:0] h_reg, h_next;
  logic [9:0] v_reg, v_next;
  logic       start_frame_reg, start_row_reg, frame_done_reg;
  logic       active_raw, hs_raw_n, vs_raw_n;

  logic [PIPE_LAT-1:0] act_pipe_reg, hs_pipe_reg, vs_pipe_reg;
  logic [9:0]          hcol_pipe_reg [PIPE_LAT];
  logic                act_d, hs_d, vs_d;
  logic [9:0]          hcol_d;

  logic [6:0]  bar_ge;
  logic [2:0]  bar_idx;
  logic [15:0] px;
  logic [4:0]  r_next, b_next;
  logic [5:0]  g_next;
  logic        hsync_reg, vsync_reg;
  logic [4:0]  r_reg, b_reg;
  logic [5:0]  g_reg;

  always_comb begin
    h_next = h_reg + 10'd1;
    v_next = v_reg;
    if (h_reg == H_LAST) begin
      h_next = '0;
      v_next = (v_reg == V_LAST) ? '0 : v_reg + 10'd1;
    end
  end

  assign active_raw = (h_reg < H_VIS) && (v_reg < V_VIS);
  assign hs_raw_n   = !((h_reg >= HS_START) && (h_reg < HS_END));
  assign vs_raw_n   = !((v_reg >= VS_START) && (v_reg < VS_END));

  // Control flags are computed from the next counter value so they line up with vga_*_counter.
  always_ff @(posedge clk_25M or negedge rst_n_25M) begin
    if (!rst_n_25M) begin
      h_reg           <= '0;
      v_reg           <= '0;
      start_frame_reg <= 1'b0;
      start_row_reg   <= 1'b0;
      frame_done_reg  <= 1'b0;
    end else begin
      h_reg           <= h_next;
      v_reg           <= v_next;
      start_frame_reg <= (v_next == V_LAST);
      start_row_reg   <= (h_next >= H_VIS) && (h_next < ROW_END) &&
                         ((v_next == V_LAST) || (v_next < V_ROW_LAST));
      frame_done_reg  <= (h_next == H_LAST) && (v_next == V_LAST);
    end
  end

  // Delay line matching the row buffer read latency, so column k meets its pixel.
  always_ff @(posedge clk_25M or negedge rst_n_25M) begin
    if (!rst_n_25M) begin
      act_pipe_reg <= '0;
      hs_pipe_reg  <= '1;
      vs_pipe_reg  <= '1;
      for (int i = 0; i < PIPE_LAT; i++) hcol_pipe_reg[i] <= '0;
    end else begin
      act_pipe_reg[0]  <= active_raw;
      hs_pipe_reg[0]   <= hs_raw_n;
      vs_pipe_reg[0]   <= vs_raw_n;
      hcol_pipe_reg[0] <= h_reg;
      for (int i = 1; i < PIPE_LAT; i++) begin
        act_pipe_reg[i]  <= act_pipe_reg[i-1];
        hs_pipe_reg[i]   <= hs_pipe_reg[i-1];
        vs_pipe_reg[i]   <= vs_pipe_reg[i-1];
        hcol_pipe_reg[i] <= hcol_pipe_reg[i-1];
      end
    end
  end

  assign act_d  = act_pipe_reg[PIPE_LAT-1];
  assign hs_d   = hs_pipe_reg[PIPE_LAT-1];
  assign vs_d   = vs_pipe_reg[PIPE_LAT-1];
  assign hcol_d = hcol_pipe_reg[PIPE_LAT-1];

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_bar_edge
      assign bar_ge[gi] = (hcol_d >= 10'(BAR_W * (gi + 1)));
    end
  endgenerate

  always_comb begin
    bar_idx = '0;
    for (int i = 0; i < 7; i++) bar_idx = bar_idx + {2'b00, bar_ge[i]};
  end

  assign px = (SWAP_BYTES != 0) ? {pixel_data[7:0], pixel_data[15:8]} : pixel_data;

  // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to inverted index bits.
  always_comb begin
    r_next = '0;
    g_next = '0;
    b_next = '0;
    if (act_d) begin
      if (test_pattern) begin
        r_next = {5{~bar_idx[1]}};
        g_next = {6{~bar_idx[2]}};
        b_next = {5{~bar_idx[0]}};
      end else begin
        r_next = px[15:11];
        g_next = px[10:5];
        b_next = px[4:0];
      end
    end
  end

  always_ff @(posedge clk_25M or negedge rst_n_25M) begin
    if (!rst_n_25M) begin
      hsync_reg <= 1'b1;
      vsync_reg <= 1'b1;
      r_reg     <= '0;
      g_reg     <= '0;
      b_reg     <= '0;
    end else begin
      hsync_reg <= hs_d;
      vsync_reg <= vs_d;
      r_reg     <= r_next;
      g_reg     <= g_next;
      b_reg     <= b_next;
    end
  end

  assign vga_h_counter = h_reg;
  assign vga_v_counter = v_reg;
  assign start_frame   = start_frame_reg;
  assign start_row     = start_row_reg;
  assign frame_done    = frame_done_reg;
  assign vga_hsync     = hsync_reg;
  assign vga_vsync     = vsync_reg;
  assign vga_r         = r_reg;
  assign vga_g         = g_reg;
  assign vga_b         = b_reg;

endmodule

// File: tb/tb_vga_timing_out.sv
// Self-checking bench for vga_timing_out, run with a shrunken raster so several
// whole frames fit in a short simulation; expectations come from raster arithmetic.
module tb_vga_timing_out;

  localparam int HV = 64, HF = 8, HSW = 12, HT = 100;
  localparam int VV = 12, VF = 2, VSW = 2, VT = 20;
  localparam int RL = 6, PL = 2;
  localparam int FRAME = HT * VT;

  logic        clk_25M = 1'b0;
  logic        rst_n_25M = 1'b0;
  logic [15:0] pixel_data = '0;
  logic        test_pattern = 1'b0;
  logic [9:0]  vga_h_counter, vga_v_counter;
  logic        start_frame, start_row, vga_hsync, vga_vsync, frame_done;
  logic [4:0]  vga_r, vga_b;
  logic [5:0]  vga_g;

  vga_timing_out #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_TOTAL(VT),
    .PIPE_LAT(PL), .ROW_REQ_LEN(RL), .SWAP_BYTES(1)
  ) dut (
    .clk_25M(clk_25M), .rst_n_25M(rst_n_25M), .pixel_data(pixel_data),
    .test_pattern(test_pattern), .vga_h_counter(vga_h_counter),
    .vga_v_counter(vga_v_counter), .start_frame(start_frame), .start_row(start_row),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .frame_done(frame_done)
  );

  always #5 clk_25M = ~clk_25M;

  int n_cmp = 0, n_err = 0;
  int e = 0;            // rising edges since reset release = raster position index
  int mode = 0;
  int frame_no = 0;
  int t_sr = 0, t_sf = 0, t_hs = 0, t_vs = 0, t_fd = 0;
  logic prev_sr = 1'b0;
  int bar_r [8] = '{31, 31, 0, 0, 31, 31, 0, 0};
  int bar_g [8] = '{63, 63, 63, 63, 0, 0, 0, 0};
  int bar_b [8] = '{31, 0, 31, 0, 31, 0, 31, 0};

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at e=%0d: got %0d expected %0d", tag, e, got, exp);
    end
  endtask

  task automatic check_all();
    int h, v, t, hd, vd, bar, er, eg, eb;
    logic act, hs, vs;
    logic [15:0] px;
    h = e % HT;
    v = (e / HT) % VT;
    chk("h_counter", int'(vga_h_counter), h);
    chk("v_counter", int'(vga_v_counter), v);
    chk("start_frame", int'(start_frame), (v == VT - 1) ? 1 : 0);
    chk("start_row", int'(start_row),
        (h >= HV && h < HV + RL && (v == VT - 1 || v < VV - 1)) ? 1 : 0);
    chk("frame_done", int'(frame_done), (h == HT - 1 && v == VT - 1) ? 1 : 0);
    // Outputs after edge e show the raster position PL+1 edges earlier.
    t = e - (PL + 1);
    if (t >= 0) begin
      hd = t % HT;
      vd = (t / HT) % VT;
      act = (hd < HV) && (vd < VV);
      hs = !(hd >= HV + HF && hd < HV + HF + HSW);
      vs = !(vd >= VV + VF && vd < VV + VF + VSW);
    end else begin
      hd = 0; act = 1'b0; hs = 1'b1; vs = 1'b1;
    end
    er = 0; eg = 0; eb = 0;
    if (act) begin
      if (test_pattern) begin
        bar = hd / (HV / 8);
        er = bar_r[bar]; eg = bar_g[bar]; eb = bar_b[bar];
      end else begin
        px = {pixel_data[7:0], pixel_data[15:8]};
        er = int'(px[15:11]); eg = int'(px[10:5]); eb = int'(px[4:0]);
      end
    end
    chk("hsync", int'(vga_hsync), int'(hs));
    chk("vsync", int'(vga_vsync), int'(vs));
    chk("red", int'(vga_r), er);
    chk("green", int'(vga_g), eg);
    chk("blue", int'(vga_b), eb);
  endtask

  task automatic clear_tally();
    t_sr = 0; t_sf = 0; t_hs = 0; t_vs = 0; t_fd = 0; prev_sr = 1'b0;
  endtask

  task automatic drive_inputs();
    case (mode)
      0: begin pixel_data = 16'($urandom); test_pattern = 1'($urandom_range(0, 1)); end
      1: begin pixel_data = 16'h1F00; test_pattern = 1'b0; end
      2: begin pixel_data = 16'($urandom); test_pattern = 1'b1; end
      default: begin
        pixel_data = 16'($urandom);
        if ($urandom_range(0, 15) == 0) test_pattern = ~test_pattern;
      end
    endcase
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk_25M);
      e++;
      @(negedge clk_25M);
      check_all();
      if (start_row && !prev_sr) t_sr++;
      prev_sr = start_row;
      t_sf += int'(start_frame);
      t_hs += int'(!vga_hsync);
      t_vs += int'(!vga_vsync);
      t_fd += int'(frame_done);
      if (e % FRAME == 0) begin
        chk("row_pulses", t_sr, VV);
        chk("sf_cycles", t_sf, HT);
        chk("hs_low_cycles", t_hs, HSW * VT);
        chk("vs_low_cycles", t_vs, VSW * HT);
        chk("fd_pulses", t_fd, 1);
        $display("frame %0d mode %0d: row_pulses=%0d sf=%0d hs_low=%0d vs_low=%0d fd=%0d",
                 frame_no, mode, t_sr, t_sf, t_hs, t_vs, t_fd);
        frame_no++;
        clear_tally();
      end
      drive_inputs();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_25M);
    e = 0;
    check_all();
    mode = 1;
    drive_inputs();
    rst_n_25M = 1'b1;
    run_cycles(FRAME);
    mode = 0;
    run_cycles(FRAME);
    mode = 3;
    run_cycles(5 * HT + 30);
    // Asynchronous reset in mid-frame at line 5, column 30.
    #2 rst_n_25M = 1'b0;
    #1;
    e = 0;
    clear_tally();
    check_all();
    $display("mid-frame reset asserted: h=%0d v=%0d hsync=%0d vsync=%0d",
             vga_h_counter, vga_v_counter, vga_hsync, vga_vsync);
    repeat (5) begin
      @(negedge clk_25M);
      check_all();
    end
    mode = 2;
    drive_inputs();
    rst_n_25M = 1'b1;
    run_cycles(FRAME);
    mode = 0;
    run_cycles(FRAME);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
